// File: rtl/usb_protocol_controller.sv
// usb_protocol_controller: full-speed endpoint transaction sequencer driving TX requests, bus direction and status.
module usb_protocol_controller #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rx_packet,
    input  logic       tx_done,
    input  logic       buffer_reserved,
    input  logic [6:0] tx_packet_data_size,
    input  logic [6:0] buffer_occupancy,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       clear,
    output logic [1:0] tx_packet,
    output logic       d_mode
);
    localparam logic [2:0] P_IDLE = 3'd0, P_IN = 3'd1, P_OUT = 3'd2, P_DATA = 3'd3,
                           P_GOOD = 3'd4, P_BAD = 3'd5, P_ACK = 3'd6;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RX_CLEAR, S_RX_WAIT, S_RX_RECV, S_RX_ACK, S_RX_DONE, S_RX_NAK,
        S_RX_DROP, S_DROP_NAK, S_TX_DATA, S_TX_WAIT_ACK, S_TX_NAK
    } state_t;

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic to, waiting, rx_set, tx_set, stray;

    assign to = cnt == CW'(TIMEOUT);
    assign waiting = state inside {S_RX_WAIT, S_RX_RECV, S_RX_DROP, S_TX_WAIT_ACK};
    // anything other than IDLE/DATA while receiving or dropping aborts the transfer
    assign stray = rx_packet != P_IDLE && rx_packet != P_DATA;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rx_error <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= (nxt != state || !waiting) ? '0 : cnt + 1'b1;
            rx_error <= (state == S_IDLE && rx_packet == P_OUT) ? 1'b0 : (rx_set ? 1'b1 : rx_error);
            tx_error <= (state == S_IDLE && rx_packet == P_IN) ? 1'b0 : (tx_set ? 1'b1 : tx_error);
        end
    end

    always_comb begin
        nxt    = state;
        rx_set = 1'b0;
        tx_set = 1'b0;
        case (state)
            S_IDLE:
                if (rx_packet == P_OUT) nxt = buffer_reserved ? S_RX_DROP : S_RX_CLEAR;
                else if (rx_packet == P_IN)
                    nxt = (buffer_occupancy >= tx_packet_data_size && !buffer_reserved) ? S_TX_DATA : S_TX_NAK;
            S_RX_CLEAR: nxt = S_RX_WAIT;
            S_RX_WAIT:
                if (rx_packet == P_DATA) nxt = S_RX_RECV;
                else if (rx_packet != P_IDLE || to) begin
                    nxt    = S_IDLE;
                    rx_set = 1'b1;
                end
            S_RX_RECV:
                if (rx_packet == P_GOOD) nxt = S_RX_ACK;
                else if (rx_packet == P_BAD) begin
                    nxt    = S_RX_NAK;
                    rx_set = 1'b1;
                end else if (stray || to) begin
                    nxt    = S_IDLE;
                    rx_set = 1'b1;
                end
            S_RX_ACK:  nxt = tx_done ? S_RX_DONE : S_RX_ACK;
            S_RX_DONE: nxt = S_IDLE;
            S_RX_NAK:  nxt = tx_done ? S_IDLE : S_RX_NAK;
            S_RX_DROP:
                if (rx_packet == P_GOOD || rx_packet == P_BAD) nxt = S_DROP_NAK;
                else if (stray || to) begin
                    nxt    = S_IDLE;
                    rx_set = 1'b1;
                end
            S_DROP_NAK: nxt = tx_done ? S_IDLE : S_DROP_NAK;
            S_TX_DATA:  nxt = tx_done ? S_TX_WAIT_ACK : S_TX_DATA;
            S_TX_WAIT_ACK:
                if (rx_packet == P_ACK) nxt = S_IDLE;
                else if (rx_packet != P_IDLE || to) begin
                    nxt    = S_IDLE;
                    tx_set = 1'b1;
                end
            S_TX_NAK: nxt = tx_done ? S_IDLE : S_TX_NAK;
            default:  nxt = S_IDLE;
        endcase
    end

    assign rx_data_ready      = state == S_RX_DONE;
    assign rx_transfer_active = state inside {S_RX_CLEAR, S_RX_WAIT, S_RX_RECV, S_RX_ACK, S_RX_NAK, S_RX_DROP, S_DROP_NAK};
    assign tx_transfer_active = state inside {S_TX_DATA, S_TX_WAIT_ACK};
    assign clear              = state == S_RX_CLEAR;
    assign tx_packet          = state == S_TX_DATA ? 2'd1 :
                                state == S_RX_ACK ? 2'd2 :
                                (state inside {S_RX_NAK, S_DROP_NAK, S_TX_NAK}) ? 2'd3 : 2'd0;
    assign d_mode             = state inside {S_RX_ACK, S_RX_NAK, S_DROP_NAK, S_TX_DATA, S_TX_NAK};
endmodule

// File: tb/tb_usb_protocol_controller.sv
// tb_usb_protocol_controller: directed stimulus with an expected-output queue checked by an independent monitor.
module tb_usb_protocol_controller;
    logic       tb_clk = 0;
    logic       rst = 1;
    logic [2:0] rx_packet = 0;
    logic       tx_done = 0;
    logic       buffer_reserved = 0;
    logic [6:0] tx_packet_data_size = 0;
    logic [6:0] buffer_occupancy = 0;
    logic       rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active, tx_error, clear, d_mode;
    logic [1:0] tx_packet;
    logic       cfg_br = 0;
    logic [6:0] cfg_sz = 0, cfg_occ = 0;

    typedef struct {
        logic [8:0] v;
        string      n;
    } exp_t;
    exp_t q[$];
    int checks = 0, passes = 0;

    localparam logic [2:0] IDLE = 0, IN = 1, OUT = 2, DATA = 3, GOOD = 4, BAD = 5, ACK = 6, NAK = 7;

    usb_protocol_controller dut (
        .clk(tb_clk), .rst(rst), .rx_packet(rx_packet), .tx_done(tx_done),
        .buffer_reserved(buffer_reserved), .tx_packet_data_size(tx_packet_data_size),
        .buffer_occupancy(buffer_occupancy), .rx_data_ready(rx_data_ready),
        .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
        .tx_transfer_active(tx_transfer_active), .tx_error(tx_error), .clear(clear),
        .tx_packet(tx_packet), .d_mode(d_mode)
    );

    always #5 tb_clk = ~tb_clk;

    // order: data_ready, rx_active, rx_error, tx_active, tx_error, clear, tx_packet[1:0], d_mode
    function automatic logic [8:0] o(input logic dr, rta, re, tta, te, clr, input logic [1:0] tp, input logic dm);
        return {dr, rta, re, tta, te, clr, tp, dm};
    endfunction

    task automatic step(input logic [2:0] p, input logic d, input logic r, input logic [8:0] e, input string n);
        @(negedge tb_clk);
        rx_packet           = p;
        tx_done             = d;
        rst                 = r;
        buffer_reserved     = cfg_br;
        tx_packet_data_size = cfg_sz;
        buffer_occupancy    = cfg_occ;
        @(posedge tb_clk);
        q.push_back('{e, n});
    endtask

    always @(negedge tb_clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [8:0] got;
            e   = q.pop_front();
            got = {rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active, tx_error, clear, tx_packet, d_mode};
            checks++;
            if (got === e.v) passes++;
            else $display("FAIL %s: got %b expected %b", e.n, got, e.v);
        end
    end

    initial begin
        logic [8:0] rwait, tdata, twait;
        rwait = o(0, 1, 0, 0, 0, 0, 0, 0);
        tdata = o(0, 0, 0, 1, 0, 0, 1, 1);
        twait = o(0, 0, 0, 1, 0, 0, 0, 0);
        step(IDLE, 0, 1, 9'd0, "reset");
        // successful OUT
        step(OUT, 0, 0, o(0, 1, 0, 0, 0, 1, 0, 0), "rx_clear");
        step(IDLE, 0, 0, rwait, "rx_wait");
        step(DATA, 0, 0, rwait, "rx_recv");
        step(GOOD, 0, 0, o(0, 1, 0, 0, 0, 0, 2, 1), "rx_ack");
        step(IDLE, 0, 0, o(0, 1, 0, 0, 0, 0, 2, 1), "rx_ack_hold");
        step(IDLE, 1, 0, o(1, 0, 0, 0, 0, 0, 0, 0), "rx_done");
        step(IDLE, 0, 0, 9'd0, "rx_idle");
        step(IDLE, 1, 0, 9'd0, "stray_done");
        // failed OUT, sticky error, clear on next OUT, abort on token
        step(OUT, 0, 0, o(0, 1, 0, 0, 0, 1, 0, 0), "rx_clear2");
        step(IDLE, 0, 0, rwait, "rx_wait2");
        step(DATA, 0, 0, rwait, "rx_recv2");
        step(BAD, 0, 0, o(0, 1, 1, 0, 0, 0, 3, 1), "rx_nak");
        step(IDLE, 1, 0, o(0, 0, 1, 0, 0, 0, 0, 0), "rx_err_sticky");
        step(IDLE, 0, 0, o(0, 0, 1, 0, 0, 0, 0, 0), "rx_err_hold");
        step(OUT, 0, 0, o(0, 1, 0, 0, 0, 1, 0, 0), "rx_err_clr");
        step(IDLE, 0, 0, rwait, "rx_wait3");
        step(ACK, 0, 0, o(0, 0, 1, 0, 0, 0, 0, 0), "rx_wait_abort");
        step(IDLE, 0, 1, 9'd0, "reset2");
        // IN transactions
        cfg_occ = 8; cfg_sz = 8;
        step(IN, 0, 0, tdata, "tx_data");
        step(IDLE, 0, 0, tdata, "tx_data_hold");
        step(IDLE, 1, 0, twait, "tx_wait_ack");
        step(ACK, 0, 0, 9'd0, "tx_ack_idle");
        step(IN, 0, 0, tdata, "tx_data2");
        step(IDLE, 1, 0, twait, "tx_wait_ack2");
        step(NAK, 0, 0, o(0, 0, 0, 0, 1, 0, 0, 0), "tx_nak_err");
        step(IDLE, 0, 0, o(0, 0, 0, 0, 1, 0, 0, 0), "tx_err_hold");
        cfg_occ = 4;
        step(IN, 0, 0, o(0, 0, 0, 0, 0, 0, 3, 1), "tx_short_nak");
        step(IDLE, 0, 0, o(0, 0, 0, 0, 0, 0, 3, 1), "tx_nak_hold");
        step(IDLE, 1, 0, 9'd0, "tx_nak_done");
        cfg_occ = 9;
        step(IN, 0, 0, tdata, "tx_occ_gt");
        step(IDLE, 1, 0, twait, "tx_wait_ack3");
        step(ACK, 0, 0, 9'd0, "tx_ack3");
        cfg_occ = 64; cfg_sz = 64; cfg_br = 1;
        step(IN, 0, 0, o(0, 0, 0, 0, 0, 0, 3, 1), "tx_reserved_nak");
        step(IDLE, 1, 0, 9'd0, "tx_reserved_done");
        // OUT while buffer reserved
        step(OUT, 0, 0, rwait, "rx_drop");
        step(GOOD, 0, 0, o(0, 1, 0, 0, 0, 0, 3, 1), "drop_nak");
        step(IDLE, 1, 0, 9'd0, "drop_done");
        cfg_br = 0; cfg_occ = 8; cfg_sz = 8;
        // IN wait-for-ACK timeout
        step(IN, 0, 0, tdata, "tx_data_to");
        step(IDLE, 1, 0, twait, "tx_wait_to_entry");
        for (int i = 0; i < 255; i++) step(IDLE, 0, 0, twait, "tx_wait_to");
        step(IDLE, 0, 0, o(0, 0, 0, 0, 1, 0, 0, 0), "tx_timeout");
        step(IDLE, 0, 1, 9'd0, "reset3");
        // OUT with no DATA timeout
        step(OUT, 0, 0, o(0, 1, 0, 0, 0, 1, 0, 0), "rx_clear_to");
        step(IDLE, 0, 0, rwait, "rx_wait_to_entry");
        for (int i = 0; i < 255; i++) step(IDLE, 0, 0, rwait, "rx_wait_to");
        step(IDLE, 0, 0, o(0, 0, 1, 0, 0, 0, 0, 0), "rx_timeout");
        // reset in the middle of a NAK send
        step(OUT, 0, 0, o(0, 1, 0, 0, 0, 1, 0, 0), "rx_clear4");
        step(IDLE, 0, 0, rwait, "rx_wait4");
        step(DATA, 0, 0, rwait, "rx_recv4");
        step(BAD, 0, 0, o(0, 1, 1, 0, 0, 0, 3, 1), "rx_nak4");
        step(IDLE, 0, 1, 9'd0, "mid_reset");
        step(IDLE, 0, 0, 9'd0, "post_reset");
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge tb_clk);
        @(posedge tb_clk);
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending expected 0", q.size());
            checks++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
